// File: rtl/multicycle_sequencer_pkg.sv
// Shared processor definitions: opcodes, sequencer states, PC/fault/ALU encodings.
package processor_pkg;

  localparam logic [5:0] OP_AND   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_ANDI  = 6'd3;
  localparam logic [5:0] OP_ADDI  = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd5;
  localparam logic [5:0] OP_LWPOI = 6'd6;
  localparam logic [5:0] OP_SW    = 6'd7;
  localparam logic [5:0] OP_BGT   = 6'd8;
  localparam logic [5:0] OP_BLT   = 6'd9;
  localparam logic [5:0] OP_BEQ   = 6'd10;
  localparam logic [5:0] OP_BNE   = 6'd11;
  localparam logic [5:0] OP_JMP   = 6'd12;
  localparam logic [5:0] OP_CALL  = 6'd13;
  localparam logic [5:0] OP_RET   = 6'd14;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_MEM    = 2'd3;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;
  localparam logic [1:0] FC_ILLEGAL   = 2'b11;

  localparam logic [1:0] ALU_AND = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_write2;
    logic       alu_src;
    logic       ext;
    logic [1:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       dm_addr_sel;
    logic       dm_data_sel;
    logic       wb_sel;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return op <= OP_RET;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_stack_pointer.sv
// CALL/RET stack pointer; sp names the next free slot and grows downward.
module stack_pointer #(
  parameter logic [31:0] SP_TOP    = 32'd255,
  parameter logic [31:0] SP_BOTTOM = 32'd192
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        dec,
  output logic [31:0] sp,
  output logic        full,
  output logic        empty
);

  assign full  = sp < SP_BOTTOM;
  assign empty = sp == SP_TOP;

  // Guards keep sp inside [SP_BOTTOM-1, SP_TOP] even if a caller misbehaves.
  always_ff @(posedge clock) begin
    if (!reset_n)             sp <= SP_TOP;
    else if (inc && !empty)   sp <= sp + 32'd1;
    else if (dec && !full)    sp <= sp - 32'd1;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer with stack pointer and sticky fault.
module multicycle_sequencer
  import processor_pkg::*;
#(
  parameter logic [31:0] SP_TOP    = 32'd255,
  parameter logic [31:0] SP_BOTTOM = 32'd192
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic        cond_taken,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        reg_write2,
  output logic        alu_src,
  output logic        ext,
  output logic [1:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        dm_addr_sel,
  output logic        dm_data_sel,
  output logic        wb_sel,
  output logic [31:0] sp,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [2:0]  state
);

  state_t     st;
  logic [5:0] op_q;
  ctrl_t      c;
  logic       sp_full, sp_empty, sp_inc, sp_dec;
  logic       is_alu, is_ld, is_br, is_stk;

  assign is_alu = op_q <= OP_ADDI;
  assign is_ld  = (op_q == OP_LW) || (op_q == OP_LWPOI);
  assign is_br  = (op_q >= OP_BGT) && (op_q <= OP_BNE);
  assign is_stk = (op_q == OP_CALL) || (op_q == OP_RET);

  // RET pre-increments in DECODE so MEM reads the last pushed slot.
  assign sp_inc = (st == S_DECODE) && (op_q == OP_RET) && !sp_empty;
  assign sp_dec = (st == S_MEM) && (op_q == OP_CALL) && mem_ready;

  stack_pointer #(.SP_TOP(SP_TOP), .SP_BOTTOM(SP_BOTTOM)) u_sp (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (sp_inc),
    .dec     (sp_dec),
    .sp      (sp),
    .full    (sp_full),
    .empty   (sp_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st          <= S_FETCH;
      op_q        <= '0;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
    end else begin
      case (st)
        S_FETCH: begin
          op_q <= opcode;
          st   <= S_DECODE;
        end
        S_DECODE: begin
          if (!op_legal(op_q)) begin
            st <= S_HALT; fault <= 1'b1; fault_cause <= FC_ILLEGAL;
          end else if (op_q == OP_JMP) begin
            st <= S_FETCH;
          end else if (op_q == OP_CALL) begin
            if (sp_full) begin
              st <= S_HALT; fault <= 1'b1; fault_cause <= FC_OVERFLOW;
            end else st <= S_MEM;
          end else if (op_q == OP_RET) begin
            if (sp_empty) begin
              st <= S_HALT; fault <= 1'b1; fault_cause <= FC_UNDERFLOW;
            end else st <= S_MEM;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC:  st <= is_br ? S_FETCH : (is_alu ? S_WB : S_MEM);
        S_MEM:   if (mem_ready) st <= is_ld ? S_WB : S_FETCH;
        S_WB:    st <= S_FETCH;
        default: st <= S_HALT;
      endcase
    end
  end

  // Moore decode from state and latched opcode; pc_write in EXEC/MEM follows
  // cond_taken/mem_ready combinationally. Held quiet while reset is asserted.
  always_comb begin
    c = '0;
    if (reset_n) begin
      case (st)
        S_FETCH:  c.ir_write = 1'b1;
        S_DECODE: if (op_q == OP_JMP) begin
          c.pc_write = 1'b1;
          c.pc_src   = PC_JUMP;
        end
        S_EXEC: if (is_br) begin
          c.pc_write = 1'b1;
          c.pc_src   = cond_taken ? PC_BRANCH : PC_NEXT;
        end
        S_MEM: begin
          c.mem_rd      = is_ld || (op_q == OP_RET);
          c.mem_wr      = (op_q == OP_SW) || (op_q == OP_CALL);
          c.dm_addr_sel = is_stk;
          c.dm_data_sel = op_q == OP_CALL;
          c.pc_src      = (op_q == OP_CALL) ? PC_JUMP : (op_q == OP_RET) ? PC_MEM : PC_NEXT;
          c.pc_write    = mem_ready && !is_ld;
        end
        S_WB: begin
          c.reg_write  = 1'b1;
          c.reg_write2 = op_q == OP_LWPOI;
          c.wb_sel     = is_ld;
          c.pc_write   = 1'b1;
        end
        default: ;
      endcase
      if (st == S_EXEC || st == S_MEM || st == S_WB) begin
        case (op_q)
          OP_AND:  c.alu_op = ALU_AND;
          OP_ADD:  c.alu_op = ALU_ADD;
          OP_SUB:  c.alu_op = ALU_SUB;
          OP_ANDI: begin c.alu_op = ALU_AND; c.alu_src = 1'b1; end
          OP_ADDI, OP_LW, OP_LWPOI, OP_SW: begin
            c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.ext = 1'b1;
          end
          OP_BGT, OP_BLT, OP_BEQ, OP_BNE: c.alu_op = ALU_SUB;
          default: ;
        endcase
      end
    end
  end

  assign ir_write    = c.ir_write;
  assign pc_write    = c.pc_write;
  assign pc_src      = c.pc_src;
  assign reg_write   = c.reg_write;
  assign reg_write2  = c.reg_write2;
  assign alu_src     = c.alu_src;
  assign ext         = c.ext;
  assign alu_op      = c.alu_op;
  assign mem_rd      = c.mem_rd;
  assign mem_wr      = c.mem_wr;
  assign dm_addr_sel = c.dm_addr_sel;
  assign dm_data_sel = c.dm_data_sel;
  assign wb_sel      = c.wb_sel;
  assign state       = st;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: driver pushes per-instruction expectations, negedge monitor checks them.
module tb_multicycle_sequencer;

  localparam logic [31:0] TOP = 32'd255;
  localparam logic [31:0] BOT = 32'd192;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic        cond_taken = 1'b0, mem_ready = 1'b0;
  logic        ir_write, pc_write, reg_write, reg_write2, alu_src, ext;
  logic        mem_rd, mem_wr, dm_addr_sel, dm_data_sel, wb_sel, fault;
  logic [1:0]  pc_src, alu_op, fault_cause;
  logic [31:0] sp;
  logic [2:0]  state;
  logic [14:0] ctrl_vec;

  assign ctrl_vec = {ir_write, pc_write, pc_src, reg_write, reg_write2, alu_src, ext,
                     alu_op, mem_rd, mem_wr, dm_addr_sel, dm_data_sel, wb_sel};

  multicycle_sequencer #(.SP_TOP(TOP), .SP_BOTTOM(BOT)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .cond_taken(cond_taken),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_write2(reg_write2), .alu_src(alu_src), .ext(ext),
    .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .dm_addr_sel(dm_addr_sel),
    .dm_data_sel(dm_data_sel), .wb_sel(wb_sel), .sp(sp), .fault(fault),
    .fault_cause(fault_cause), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          halt;
    logic [1:0]  cause;
    logic [1:0]  pc_src;
    int          cyc;
    bit          rw, rw2, wb, rd, wr, asel, dsel, chk_ext, ext;
    int          nstrobe;
    logic [31:0] mem_sp, sp_after;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] msp = TOP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks per-instruction activity and checks on pc_write / fault rise.
  int          m_cyc, m_nstr;
  bit          m_rd, m_wr, m_asel, m_dsel, m_ext, m_prev_fault, m_pend;
  logic [31:0] m_msp, m_pend_sp;

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      m_cyc = 0; m_nstr = 0; m_rd = 0; m_wr = 0; m_asel = 0; m_dsel = 0;
      m_ext = 0; m_prev_fault = 0; m_pend = 0; m_msp = '0;
    end else begin
      if (ir_write) begin
        if (m_pend) chk("sp_after", sp, m_pend_sp);
        m_pend = 0; m_cyc = 0; m_nstr = 0;
        m_rd = 0; m_wr = 0; m_asel = 0; m_dsel = 0; m_ext = 0;
      end else m_cyc++;
      if (m_cyc == 2) m_ext = ext;
      if (mem_rd || mem_wr) begin
        m_nstr++; m_rd |= mem_rd; m_wr |= mem_wr;
        m_asel = dm_addr_sel; m_dsel = dm_data_sel; m_msp = sp;
      end
      if (pc_write) begin
        if (q.size() == 0) chk("unexpected_pc_write", 1, 0);
        else begin
          e = q.pop_front();
          chk("halt_expected_got_pc_write", {31'd0, e.halt}, 0);
          chk("pc_src", pc_src, e.pc_src);
          chk("pc_write_cycle", m_cyc, e.cyc);
          chk("reg_write", reg_write, e.rw);
          chk("reg_write2", reg_write2, e.rw2);
          chk("wb_sel", wb_sel, e.wb);
          chk("mem_cycles", m_nstr, e.nstrobe);
          chk("mem_rd_seen", m_rd, e.rd);
          chk("mem_wr_seen", m_wr, e.wr);
          if (e.nstrobe != 0) begin
            chk("dm_addr_sel", m_asel, e.asel);
            chk("dm_data_sel", m_dsel, e.dsel);
            if (e.asel) chk("stack_addr", m_msp, e.mem_sp);
          end
          if (e.chk_ext) chk("ext", m_ext, e.ext);
          m_pend = 1; m_pend_sp = e.sp_after;
        end
      end
      if (fault && !m_prev_fault) begin
        if (q.size() == 0) chk("unexpected_fault", 1, 0);
        else begin
          e = q.pop_front();
          chk("fault_expected", {31'd0, e.halt}, 1);
          chk("fault_cause", fault_cause, e.cause);
          chk("fault_cycle", m_cyc, 2);
          chk("fault_sp", sp, e.sp_after);
        end
      end
      m_prev_fault = fault;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    cond_taken = 1'($urandom); mem_ready = 1'($urandom); opcode = 6'($urandom);
    @(posedge clock); #1;
    chk("rst_state", state, 0);
    chk("rst_sp", sp, TOP);
    chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_outputs", ctrl_vec, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    msp = TOP;
  endtask

  task automatic halt_hold(input logic [1:0] cause);
    repeat (3) begin
      cond_taken = 1'($urandom); mem_ready = 1'($urandom); opcode = 6'($urandom);
      @(posedge clock); #1;
      chk("halt_state", state, 5);
      chk("halt_fault", fault, 1);
      chk("halt_cause", fault_cause, cause);
      chk("halt_outputs", ctrl_vec, 0);
    end
  endtask

  // Called at posedge+1 of a FETCH cycle; returns at the next FETCH (or HALT).
  task automatic issue(input logic [5:0] op, input int w, input bit ct);
    exp_t e;
    int   ms, c;
    e = '{default: 0};
    ms = 0;
    if (op > 6'd14) begin
      e.halt = 1; e.cause = 2'b11;
    end else if (op <= 6'd4) begin
      e.cyc = 3; e.rw = 1; e.chk_ext = (op == 3 || op == 4); e.ext = (op == 4);
    end else if (op <= 6'd6) begin
      ms = 3; e.cyc = 4 + w; e.rw = 1; e.rw2 = (op == 6); e.wb = 1; e.rd = 1;
    end else if (op == 6'd7) begin
      ms = 3; e.cyc = 3 + w; e.wr = 1;
    end else if (op <= 6'd11) begin
      e.cyc = 2; e.pc_src = ct ? 2'd1 : 2'd0;
    end else if (op == 6'd12) begin
      e.cyc = 1; e.pc_src = 2'd2;
    end else if (op == 6'd13) begin
      if (msp < BOT) begin e.halt = 1; e.cause = 2'b01; end
      else begin
        ms = 2; e.cyc = 2 + w; e.pc_src = 2'd2; e.wr = 1; e.asel = 1; e.dsel = 1;
        e.mem_sp = msp; msp = msp - 1;
      end
    end else begin
      if (msp == TOP) begin e.halt = 1; e.cause = 2'b10; end
      else begin
        msp = msp + 1;
        ms = 2; e.cyc = 2 + w; e.pc_src = 2'd3; e.rd = 1; e.asel = 1; e.mem_sp = msp;
      end
    end
    e.nstrobe  = (ms != 0) ? w + 1 : 0;
    e.sp_after = msp;
    q.push_back(e);
    c = 0;
    forever begin
      opcode     = (c == 0) ? op : 6'($urandom);
      cond_taken = (c == 2) ? ct : 1'($urandom);
      mem_ready  = (ms != 0) ? (c >= ms + w) : 1'($urandom);
      @(posedge clock); #1;
      c++;
      if (ir_write || fault) break;
      if (c > 60) begin chk("instr_timeout", c, 0); break; end
    end
    if (e.halt) begin
      halt_hold(e.cause);
      do_reset();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, r;
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    // Directed: ALU, loads with stalls, branches, call/return pair, misc.
    issue(6'd1, 0, 0);
    issue(6'd5, 3, 0);
    issue(6'd6, 3, 0);
    issue(6'd10, 0, 1);
    issue(6'd10, 0, 0);
    issue(6'd13, 0, 0);
    issue(6'd14, 0, 0);
    issue(6'd3, 0, 0);
    issue(6'd4, 0, 0);
    issue(6'd7, 2, 0);
    issue(6'd12, 0, 0);
    issue(6'd8, 0, 1);
    // Underflow from the empty stack.
    issue(6'd14, 0, 0);
    // Fill the stack, then overflow.
    for (int i = 0; i < 64; i++) issue(6'd13, int'($urandom_range(0, 1)), 0);
    chk("sp_full_model", msp, 32'd191);
    issue(6'd13, 0, 0);
    // Illegal opcode.
    issue(6'd20, 0, 0);
    // Reset during a stalled CALL access.
    opcode = 6'd13; mem_ready = 1'b0; cond_taken = 1'b0;
    repeat (3) begin @(posedge clock); #1; opcode = 6'($urandom); end
    chk("stall_mem_wr", mem_wr, 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("abort_state", state, 0);
    chk("abort_sp", sp, TOP);
    chk("abort_mem_wr", mem_wr, 0);
    chk("abort_fault", fault, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    msp = TOP;
    // Random mix.
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 19));
      op = (r == 19) ? int'($urandom_range(15, 63)) : r % 15;
      issue(6'(op), int'($urandom_range(0, 3)), 1'($urandom));
    end
    @(negedge clock); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
